// File: rtl/hack_wb_pkg.sv
// Shared types and constants for the Hack Wishbone memory bridge:
// memory FSM states, register offsets, address-region bits, ID word and the
// timeout read pattern.
package hack_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  // Register offsets, taken from byte-address bits [3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_ID     = 2'd2;

  // Byte-address bits that select the memory region and ROM vs RAM
  localparam int MEM_BIT = 19;
  localparam int ROM_BIT = 18;

  // Bits inside CTRL and STATUS
  localparam int CTRL_RESET_BIT  = 0;
  localparam int CTRL_HOLD_BIT   = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;
  localparam int STATUS_ERR_BIT  = 1;

  localparam logic [2:0]  CTRL_RESET_VAL = 3'b001;
  localparam logic [31:0] HACK_ID        = 32'h4841_434B;  // "HACK"
  localparam logic [31:0] ERR_PATTERN    = 32'hDEAD_BEEF;

endpackage

// File: rtl/hack_wb_regfile.sv
// CTRL / STATUS / ID register file for the Hack Wishbone bridge.
// CTRL drives the Hack CPU reset, clock hold and the error-interrupt enable.
// STATUS.err is sticky, cleared by writing 1 to bit 1; a new error in the
// same cycle as the clear keeps it set. Reset is synchronous, active high.
module hack_wb_regfile
  import hack_wb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [1:0]  offset,
  input  logic        sel0,
  input  logic [2:0]  wr_data,
  input  logic        err_set,
  input  logic        busy,
  output logic [31:0] rd_data,
  output logic        cpu_reset,
  output logic        cpu_hold,
  output logic        irq
);

  logic [2:0] ctrl_q;
  logic       err_q;
  logic       byte0_wr;

  // Only byte lane 0 carries register bits, so writes need sel[0]
  assign byte0_wr = wr_en & sel0;

  // CTRL storage and sticky error flag with write-1-to-clear
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      ctrl_q <= CTRL_RESET_VAL;
      err_q  <= 1'b0;
    end else begin
      if (byte0_wr && offset == REG_CTRL) ctrl_q <= wr_data;
      if (err_set) begin
        err_q <= 1'b1;
      end else if (byte0_wr && offset == REG_STATUS && wr_data[STATUS_ERR_BIT]) begin
        err_q <= 1'b0;
      end
    end
  end

  // Read mux; unused upper bits and the unmapped offset read as zero
  always_comb begin
    rd_data = '0;
    case (offset)
      REG_CTRL:   rd_data = {29'd0, ctrl_q};
      REG_STATUS: rd_data = {30'd0, err_q, busy};
      REG_ID:     rd_data = HACK_ID;
      default:    rd_data = '0;
    endcase
  end

  assign cpu_reset = ctrl_q[CTRL_RESET_BIT];
  assign cpu_hold  = ctrl_q[CTRL_HOLD_BIT];
  assign irq       = err_q & ctrl_q[CTRL_IRQ_EN_BIT];

endmodule

// File: rtl/hack_wb_mem_bridge.sv
// Wishbone classic slave bridging the Caravel management bus to the Hack SoC.
// Decodes a register window (CTRL/STATUS/ID) and a memory window (ROM/RAM)
// and runs a req/ack memory FSM toward the SoC memory arbiter.
// Optional feature macro: HACK_WB_TIMEOUT_EN -- abandons a memory request
// after TIMEOUT_CYCLES cycles without mem_ack_i and returns ERR_PATTERN.
module hack_wb_mem_bridge
  import hack_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int          ADDR_W         = 15,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic              mem_rom_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [15:0]       mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [15:0]       mem_rdata_i,
  output logic              cpu_reset_o,
  output logic              cpu_hold_o,
  output logic              irq_o
);

  mem_state_e  state_q, state_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        abort_q, abort_d;
  logic        mem_start;
  logic        err_set;
  logic        reg_wr;
  logic [31:0] reg_rdata;
  logic        tmo_expired;

  logic cyc_stb, in_window, new_req, is_mem, mem_legal, partial_wr;

  assign cyc_stb    = wbs_cyc_i & wbs_stb_i;
  assign in_window  = (wbs_adr_i[31:20] == BASE_ADDR[31:20]);
  // ack_q guards the cycle in which the master still sees our ack
  assign new_req    = cyc_stb & in_window & ~ack_q & (state_q == ST_IDLE);
  assign is_mem     = wbs_adr_i[MEM_BIT];
  assign mem_legal  = cpu_reset_o | cpu_hold_o;
  assign partial_wr = wbs_we_i & (wbs_sel_i[1:0] != 2'b11);

  // Gating by cyc&stb keeps ack off if the master has already withdrawn
  assign wbs_ack_o = ack_q & cyc_stb;
  assign wbs_dat_o = dat_q;
  assign mem_req_o = (state_q == ST_REQ);

  // Several address, data and select bits have no function in this window
  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i, wbs_dat_i, wbs_sel_i};

`ifdef HACK_WB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt_q;

  // Counts cycles spent waiting in REQ; restarts whenever REQ is left
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || state_q != ST_REQ) tmo_cnt_q <= '0;
    else                               tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end

  assign tmo_expired = (state_q == ST_REQ) && (tmo_cnt_q == TMO_LAST);
`else
  assign tmo_expired = 1'b0;
`endif

  // Next-state, ack and read-data selection for the Wishbone/memory FSM
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    ack_d     = 1'b0;
    dat_d     = '0;
    abort_d   = abort_q;
    mem_start = 1'b0;
    err_set   = 1'b0;
    reg_wr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (new_req) begin
          if (!is_mem) begin
            ack_d  = 1'b1;
            reg_wr = wbs_we_i;
            dat_d  = wbs_we_i ? 32'd0 : reg_rdata;
          end else if (!mem_legal) begin
            // CPU still running: refuse the access and flag it
            ack_d   = 1'b1;
            err_set = 1'b1;
          end else if (partial_wr) begin
            ack_d = 1'b1;
          end else begin
            mem_start = 1'b1;
            state_d   = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // Once the master walks away the request still completes, silently
        abort_d = abort_q | ~cyc_stb;
        if (mem_ack_i) begin
          state_d = abort_d ? ST_IDLE : ST_RESP;
          ack_d   = ~abort_d;
          if (!abort_d) dat_d = {16'd0, mem_rdata_i};
        end else if (tmo_expired) begin
          state_d = abort_d ? ST_IDLE : ST_RESP;
          ack_d   = ~abort_d;
          err_set = 1'b1;
          if (!abort_d) dat_d = ERR_PATTERN;
        end
      end
      ST_RESP: begin
        // wbs_ack_o is high during this single cycle
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, registered ack/data and abort flag
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      abort_q <= abort_d;
    end
  end

  // Memory-port command registers, loaded when a request is launched
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      mem_we_o    <= 1'b0;
      mem_rom_o   <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else if (mem_start) begin
      mem_we_o    <= wbs_we_i;
      mem_rom_o   <= wbs_adr_i[ROM_BIT];
      mem_addr_o  <= wbs_adr_i[ADDR_W+1:2];
      mem_wdata_o <= wbs_dat_i[15:0];
    end
  end

  hack_wb_regfile u_regfile (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .wr_en     (reg_wr),
    .offset    (wbs_adr_i[3:2]),
    .sel0      (wbs_sel_i[0]),
    .wr_data   (wbs_dat_i[2:0]),
    .err_set   (err_set),
    .busy      (state_q != ST_IDLE),
    .rd_data   (reg_rdata),
    .cpu_reset (cpu_reset_o),
    .cpu_hold  (cpu_hold_o),
    .irq       (irq_o)
  );

endmodule
